// File: rtl/disp_pkg.sv
`default_nettype none
// disp_pkg: shared FSM state type, seven-segment constants and BCD helper for acc_display.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SHOW    = 2'd2
  } state_t;

  // Active-low segments ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// seg7_decode: BCD digit to active-low seven-segment pattern; codes above 9 are blank.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/acc_display.sv
`default_nettype none
// acc_display: debounces a signed 8-bit accumulator value and shows it as sign + 3 decimal digits.
// Macro DISP_LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module acc_display
  import disp_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Value,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic       Busy,
  output logic       Updated
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_t      state;
  logic [7:0]  in_q;
  logic [7:0]  shown_q;
  logic [3:0]  stab_cnt;
  logic [8:0]  mag_q;
  logic [11:0] bcd_q;
  logic [2:0]  iter_q;
  logic [7:0]  abs_in;
  logic [3:0]  units_adj;
  logic [3:0]  tens_adj;
  logic [6:0]  seg_units;
  logic [6:0]  seg_tens;
  logic [6:0]  seg_hund;
  logic [6:0]  hex1_show;
  logic [6:0]  hex2_show;

  // 8-bit negate of 0x80 yields 0x80, which read unsigned is the required 128
  assign abs_in    = in_q[7] ? (~in_q) + 8'd1 : in_q;
  assign units_adj = add3(bcd_q[3:0]);
  assign tens_adj  = add3(bcd_q[7:4]);

  seg7_decode u_units (.bcd(bcd_q[3:0]),  .seg(seg_units));
  seg7_decode u_tens  (.bcd(bcd_q[7:4]),  .seg(seg_tens));
  seg7_decode u_hund  (.bcd(bcd_q[11:8]), .seg(seg_hund));

`ifdef DISP_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] UPPER_RST = SEG_BLANK;
  logic hund_zero;
  logic tens_zero;
  assign hund_zero = (bcd_q[11:8] == 4'd0);
  assign tens_zero = (bcd_q[7:4] == 4'd0);
  assign hex2_show = hund_zero ? SEG_BLANK : seg_hund;
  assign hex1_show = (hund_zero && tens_zero) ? SEG_BLANK : seg_tens;
`else
  localparam logic [6:0] UPPER_RST = SEG_0;
  assign hex2_show = seg_hund;
  assign hex1_show = seg_tens;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= ST_IDLE;
      in_q     <= '0;
      stab_cnt <= '0;
      shown_q  <= '0;
      mag_q    <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      Busy     <= 1'b0;
      Updated  <= 1'b0;
      HEX0     <= SEG_0;
      HEX1     <= UPPER_RST;
      HEX2     <= UPPER_RST;
      HEX3     <= SEG_BLANK;
    end else begin
      in_q    <= Value;
      Updated <= 1'b0;
      if (Value != in_q)
        stab_cnt <= '0;
      else if (stab_cnt != SETTLE)
        stab_cnt <= stab_cnt + 4'd1;

      case (state)
        ST_IDLE: begin
          if (stab_cnt == SETTLE && in_q != shown_q) begin
            state   <= ST_CONVERT;
            Busy    <= 1'b1;
            shown_q <= in_q;
            // magnitude kept left-aligned so each iteration shifts out bit 8
            mag_q   <= {abs_in, 1'b0};
            bcd_q   <= '0;
            iter_q  <= '0;
          end
        end
        ST_CONVERT: begin
          // hundreds never exceeds 1 for |x| <= 128, so it needs no add-3
          bcd_q  <= {bcd_q[10:8], tens_adj, units_adj, mag_q[8]};
          mag_q  <= {mag_q[7:0], 1'b0};
          iter_q <= iter_q + 3'd1;
          if (iter_q == 3'd7)
            state <= ST_SHOW;
        end
        ST_SHOW: begin
          HEX0    <= seg_units;
          HEX1    <= hex1_show;
          HEX2    <= hex2_show;
          HEX3    <= shown_q[7] ? SEG_MINUS : SEG_BLANK;
          Updated <= 1'b1;
          Busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_display.sv
`default_nettype none
// tb_acc_display: randomized scoreboard bench for acc_display with a decimal-arithmetic reference model.
module tb_acc_display;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value = 8'd0;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic       busy, updated;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         at;
    logic [6:0] h0, h1, h2, h3;
  } exp_t;

  exp_t q[$];
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int         chg_at  = 0;
  int         free_at = 0;
  logic [7:0] shown_m = 8'd0;
  logic       rst_at_edge = 1'b1;
  logic [27:0] prev_hex;

  acc_display #(.SETTLE_CYCLES(S)) dut (
    .Clock  (clk),
    .Reset  (rst),
    .Value  (value),
    .HEX0   (hex0),
    .HEX1   (hex1),
    .HEX2   (hex2),
    .HEX3   (hex3),
    .Busy   (busy),
    .Updated(updated)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    rst_at_edge = rst;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t make_exp(input logic [7:0] v, input int at);
    exp_t e;
    int sv, mag, h, t, u;
    sv  = int'($signed(v));
    mag = (sv < 0) ? -sv : sv;
    h = mag / 100;
    t = (mag / 10) % 10;
    u = mag % 10;
    e.at = at;
    e.h0 = seg_tab[u];
    e.h1 = seg_tab[t];
    e.h2 = seg_tab[h];
    e.h3 = (sv < 0) ? 7'h3F : 7'h7F;
`ifdef DISP_LEADING_ZERO_BLANK_EN
    if (h == 0) e.h2 = 7'h7F;
    if (h == 0 && t == 0) e.h1 = 7'h7F;
`endif
    return e;
  endfunction

  // A value stable since chg_at is shown once the unit is free, if it differs from what is shown.
  task automatic expect_stable(input logic [7:0] v);
    int start;
    if (v != shown_m) begin
      start = chg_at + S + 1;
      if (free_at > start) start = free_at;
      q.push_back(make_exp(v, start + 9));
      shown_m = v;
      free_at = start + 10;
    end
  endtask

  task automatic step(input logic [7:0] v);
    @(posedge clk);
    #1;
    if (v !== value) chg_at = cyc + 1;
    value = v;
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    step(v);
    expect_stable(v);
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic chk_reset_state();
`ifdef DISP_LEADING_ZERO_BLANK_EN
    int upper = 'h7F;
`else
    int upper = 'h40;
`endif
    chk("reset_hex0", hex0, 'h40);
    chk("reset_hex1", hex1, upper);
    chk("reset_hex2", hex2, upper);
    chk("reset_hex3", hex3, 'h7F);
    chk("reset_busy", busy, 0);
    chk("reset_updated", updated, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", q.size(), 0);
  endtask

  // Monitor: every Updated pulse must match the oldest expected display.
  always @(negedge clk) begin
    exp_t e;
    if (updated) begin
      if (q.size() == 0) begin
        chk("unexpected_updated", 1, 0);
      end else begin
        e = q.pop_front();
        chk("update_cycle", cyc, e.at);
        chk("hex0", hex0, e.h0);
        chk("hex1", hex1, e.h1);
        chk("hex2", hex2, e.h2);
        chk("hex3", hex3, e.h3);
        chk("busy_at_update", busy, 0);
      end
    end
    if (!rst_at_edge && {hex3, hex2, hex1, hex0} !== prev_hex)
      chk("hex_change_with_updated", updated, 1);
    prev_hex = {hex3, hex2, hex1, hex0};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] v, a, b;
    logic [7:0] corners [8] = '{8'd0, 8'd127, 8'h80, 8'hFF, 8'd100, 8'd99, 8'd9, 8'd10};
    int n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state();
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero held after reset never triggers a display
    hold(8'd0, 50);
    @(negedge clk);
    chk("idle_hex0", hex0, 'h40);
    chk("idle_hex3", hex3, 'h7F);

    hold(8'd127, S + 14);
    hold(8'h80, S + 14);

    // Alternating input never settles; the final held 6 does
    for (int i = 0; i < 20; i++) step((i % 2 == 0) ? 8'd5 : 8'd6);
    hold(8'd6, S + 14);

    // Change during conversion is deferred, then displayed
    hold(8'd10, S + 3);
    hold(8'd99, S + 30);

    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 5))
        0:       v = shown_m;
        1, 2:    v = corners[$urandom_range(0, 7)];
        default: v = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 2) == 0) begin
        a = 8'($urandom_range(0, 255));
        b = a ^ 8'($urandom_range(1, 255));
        n = $urandom_range(2, 8);
        for (int i = 0; i < n; i++) step((i % 2 == 0) ? a : b);
      end
      hold(v, S + 14);
    end
    drain();

    // Reset in the middle of a conversion aborts it silently
    step(8'd55);
    repeat (S + 2) @(posedge clk);
    @(negedge clk);
    chk("busy_mid_convert", busy, 1);
    rst   = 1'b1;
    value = 8'd0;
    @(negedge clk);
    chk_reset_state();
    @(posedge clk);
    #1 rst = 1'b0;
    shown_m = 8'd0;
    free_at = 0;
    hold(8'd0, 30);

    hold(8'hFF, S + 14);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
